// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding the instruction decoder.
// Holds the PC, reads one 16-bit word per request over a MemRd/MemRdy handshake,
// latches it into Instr and presents a one-cycle E strobe for the decoder.
// Build option: define IFETCH_ALIGN_FLT_EN to trap odd fetch addresses into a
// sticky fault (FLTo); by default bit 0 of every loaded fetch address is cleared.
`timescale 1ns/1ps
module instruction_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Run,
  input  logic              Stall,
  input  logic              BrTaken,
  input  logic [ADDR_W-1:0] BrTarget,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic              MemRdy,
  input  logic [15:0]       MemData,
  output logic [15:0]       Instr,
  output logic              E,
  output logic [ADDR_W-1:0] PC,
  output logic              FLTo
);

  // state | meaning
  // IDLE  | no request outstanding, waiting for Run
  // REQ   | MemRd high at MemAddr, waiting for MemRdy
  // ISSUE | word latched in Instr/PC, waiting for Stall low to strobe E
  // FLT   | odd fetch address trapped, frozen until reset
  typedef enum logic [1:0] {IDLE, REQ, ISSUE, FLT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              rd_q, rd_d;
  logic              e_q, e_d;
  logic              flt_q, flt_d;
  logic [ADDR_W-1:0] br_tgt;

`ifdef IFETCH_ALIGN_FLT_EN
  localparam bit                ALIGN_FLT = 1'b1;
  localparam logic [ADDR_W-1:0] RST_PC    = RESET_PC;
  assign br_tgt = BrTarget;
`else
  localparam bit                ALIGN_FLT = 1'b0;
  localparam logic [ADDR_W-1:0] EVEN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] RST_PC    = RESET_PC & EVEN_MASK;
  assign br_tgt = BrTarget & EVEN_MASK;
`endif

  // Next-state and next-output decode; BrTaken outranks MemRdy and Stall.
  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    rd_d    = rd_q;
    e_d     = 1'b0;
    flt_d   = flt_q;
    case (state_q)
      IDLE: begin
        rd_d = 1'b0;
        if (BrTaken) fetch_d = br_tgt;
        if (Run) begin
          if (ALIGN_FLT && fetch_d[0]) begin
            state_d = FLT;
            flt_d   = 1'b1;
          end else begin
            state_d = REQ;
            rd_d    = 1'b1;
            addr_d  = fetch_d;
          end
        end
      end
      REQ: begin
        if (BrTaken) begin
          // Abort: drop MemRd, pass through IDLE so MemRd stays low a cycle.
          fetch_d = br_tgt;
          rd_d    = 1'b0;
          state_d = IDLE;
        end else if (MemRdy) begin
          instr_d = MemData;
          pc_d    = fetch_q;
          fetch_d = fetch_q + ADDR_W'(2);
          rd_d    = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (BrTaken || !Stall) begin
          if (BrTaken) fetch_d = br_tgt;
          else         e_d     = 1'b1;
          if (!Run) begin
            state_d = IDLE;
          end else if (ALIGN_FLT && fetch_d[0]) begin
            state_d = FLT;
            flt_d   = 1'b1;
          end else begin
            state_d = REQ;
            rd_d    = 1'b1;
            addr_d  = fetch_d;
          end
        end
      end
      FLT: begin
        rd_d  = 1'b0;
        flt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      fetch_q <= RST_PC;
      addr_q  <= RST_PC;
      pc_q    <= RST_PC;
      instr_q <= 16'h0000;
      rd_q    <= 1'b0;
      e_q     <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rd_q    <= rd_d;
      e_q     <= e_d;
      flt_q   <= flt_d;
    end
  end

  assign MemAddr = addr_q;
  assign MemRd   = rd_q;
  assign Instr   = instr_q;
  assign E       = e_q;
  assign PC      = pc_q;
  assign FLTo    = flt_q;

endmodule
